instr_encoder: RTL and testbench

INSTR_ENCODER -- requirements
Module: instr_encoder

---
 rtl/instr_encoder.sv | 131 +++++++++++++
 tb/tb_instr_encoder.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_encoder.sv
// ============================================================================
//  Module   : instr_encoder
//  Brief    : Encodes one field bundle into a 32-bit instruction word behind a
//             single output register, with illegal-bundle detection and addressing.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module instr_encoder #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [2:0]         fmt,
  input  logic [6:0]         opcode,
  input  logic [2:0]         funct3,
  input  logic [6:0]         funct7,
  input  logic [4:0]         rd,
  input  logic [4:0]         rs1,
  input  logic [4:0]         rs2,
  input  logic signed [31:0] imm,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [31:0]        out_instr,
  output logic [31:0]        out_addr,
  output logic               out_err,
  output logic [7:0]         err_count
);

  localparam logic [2:0]  c_FMT_R = 3'd0;
  localparam logic [2:0]  c_FMT_I = 3'd1;
  localparam logic [2:0]  c_FMT_S = 3'd2;
  localparam logic [2:0]  c_FMT_B = 3'd3;
  localparam logic [2:0]  c_FMT_U = 3'd4;
  localparam logic [2:0]  c_FMT_J = 3'd5;
  localparam logic [31:0] c_NOP   = 32'h0000_0013;

  logic        r_out_valid;
  logic [31:0] r_out_instr;
  logic [31:0] r_addr;
  logic        r_out_err;
  logic [7:0]  r_err_count;

  logic        w_accept;
  logic        w_xfer;
  logic        w_legal;
  logic [31:0] w_enc;
  logic        w_fits_12;
  logic        w_fits_13;
  logic        w_fits_21;

  assign in_ready  = !r_out_valid || out_ready;
  assign w_accept  = in_valid && in_ready;
  assign w_xfer    = r_out_valid && out_ready;

  // Range limits of the signed immediate fields; B/J top values are the largest even offsets.
  assign w_fits_12 = (imm >= -32'sd2048)    && (imm <= 32'sd2047);
  assign w_fits_13 = (imm >= -32'sd4096)    && (imm <= 32'sd4094);
  assign w_fits_21 = (imm >= -32'sd1048576) && (imm <= 32'sd1048574);

  always_comb begin
    w_legal = 1'b0;
    w_enc   = 32'd0;
    case (fmt)
      c_FMT_R: begin
        w_legal = 1'b1;
        w_enc   = {funct7, rs2, rs1, funct3, rd, opcode};
      end
      c_FMT_I: begin
        w_legal = w_fits_12;
        w_enc   = {imm[11:0], rs1, funct3, rd, opcode};
      end
      c_FMT_S: begin
        w_legal = w_fits_12;
        w_enc   = {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode};
      end
      c_FMT_B: begin
        w_legal = w_fits_13 && !imm[0];
        w_enc   = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode};
      end
      c_FMT_U: begin
        w_legal = (imm[11:0] == 12'd0);
        w_enc   = {imm[31:12], rd, opcode};
      end
      c_FMT_J: begin
        w_legal = w_fits_21 && !imm[0];
        w_enc   = {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode};
      end
      default: begin
        w_legal = 1'b0;
        w_enc   = 32'd0;
      end
    endcase
  end

  // The address counter names the word currently held and moves only when that word leaves.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_out_valid <= 1'b0;
      r_out_instr <= 32'd0;
      r_out_err   <= 1'b0;
      r_addr      <= BASE_ADDR;
      r_err_count <= 8'd0;
    end else begin
      if (w_xfer) begin
        r_addr <= r_addr + 32'd4;
      end
      if (w_accept) begin
        r_out_valid <= 1'b1;
        r_out_instr <= w_legal ? w_enc : c_NOP;
        r_out_err   <= !w_legal;
        if (!w_legal && (r_err_count != 8'hFF)) begin
          r_err_count <= r_err_count + 8'd1;
        end
      end else if (w_xfer) begin
        r_out_valid <= 1'b0;
      end
    end
  end

  assign out_valid = r_out_valid;
  assign out_instr = r_out_instr;
  assign out_addr  = r_addr;
  assign out_err   = r_out_err;
  assign err_count = r_err_count;

endmodule

`default_nettype wire

// File: tb/tb_instr_encoder.sv
// ============================================================================
//  Module   : tb_instr_encoder
//  Brief    : Self-checking bench for instr_encoder: directed vector table,
//             handshake/reset sequences and a randomized scoreboard run.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module tb_instr_encoder;

  localparam logic [31:0] BASE = 32'h0000_1000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [2:0]  fmt = 3'd0;
  logic [6:0]  opcode = 7'd0;
  logic [2:0]  funct3 = 3'd0;
  logic [6:0]  funct7 = 7'd0;
  logic [4:0]  rd = 5'd0;
  logic [4:0]  rs1 = 5'd0;
  logic [4:0]  rs2 = 5'd0;
  logic [31:0] imm = 32'd0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_instr;
  logic [31:0] out_addr;
  logic        out_err;
  logic [7:0]  err_count;

  int total = 0;
  int bad   = 0;

  instr_encoder #(.BASE_ADDR(BASE)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .fmt(fmt), .opcode(opcode), .funct3(funct3), .funct7(funct7),
    .rd(rd), .rs1(rs1), .rs2(rs2), .imm(imm),
    .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr),
    .out_addr(out_addr), .out_err(out_err), .err_count(err_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  fmt;
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [31:0] imm;
    logic [31:0] exp_instr;
    logic        exp_err;
  } vec_t;

  typedef struct {
    logic [2:0]  fmt;
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [31:0] imm;
    bit          err;
  } bundle_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [2:0] f, input logic [6:0] op, input logic [2:0] f3,
                       input logic [6:0] f7, input logic [4:0] d, input logic [4:0] s1,
                       input logic [4:0] s2, input logic [31:0] im);
    fmt = f; opcode = op; funct3 = f3; funct7 = f7; rd = d; rs1 = s1; rs2 = s2; imm = im;
    in_valid = 1'b1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  function automatic vec_t mk(input logic [2:0] f, input logic [6:0] op, input logic [2:0] f3,
                              input logic [6:0] f7, input logic [4:0] d, input logic [4:0] s1,
                              input logic [4:0] s2, input logic [31:0] im,
                              input logic [31:0] ei, input logic ee);
    vec_t v;
    v.fmt = f; v.opcode = op; v.funct3 = f3; v.funct7 = f7; v.rd = d; v.rs1 = s1;
    v.rs2 = s2; v.imm = im; v.exp_instr = ei; v.exp_err = ee;
    return v;
  endfunction

  // Legality from the numeric ranges of each format.
  function automatic bit model_illegal(input logic [2:0] f, input logic [31:0] im);
    int v;
    v = $signed(im);
    case (f)
      3'd0:       return 1'b0;
      3'd1, 3'd2: return !(v >= -2048 && v <= 2047);
      3'd3:       return !(v >= -4096 && v <= 4094 && (v % 2) == 0);
      3'd4:       return (v % 4096) != 0;
      3'd5:       return !(v >= -1048576 && v <= 1048574 && (v % 2) == 0);
      default:    return 1'b1;
    endcase
  endfunction

  // Decodes a produced word back into fields and compares with the bundle that went in.
  function automatic bit word_ok(input bundle_t b, input logic [31:0] x);
    logic [31:0] d;
    bit ok;
    d  = 32'd0;
    ok = 1'b1;
    if (b.err) return (x == 32'h0000_0013);
    ok = (x[6:0] == b.opcode);
    case (b.fmt)
      3'd0: ok = ok && x[11:7] == b.rd && x[14:12] == b.funct3 && x[19:15] == b.rs1 &&
                 x[24:20] == b.rs2 && x[31:25] == b.funct7;
      3'd1: begin
        d  = {{20{x[31]}}, x[31:20]};
        ok = ok && d == b.imm && x[11:7] == b.rd && x[14:12] == b.funct3 && x[19:15] == b.rs1;
      end
      3'd2: begin
        d  = {{20{x[31]}}, x[31:25], x[11:7]};
        ok = ok && d == b.imm && x[14:12] == b.funct3 && x[19:15] == b.rs1 && x[24:20] == b.rs2;
      end
      3'd3: begin
        d  = {{19{x[31]}}, x[31], x[7], x[30:25], x[11:8], 1'b0};
        ok = ok && d == b.imm && x[14:12] == b.funct3 && x[19:15] == b.rs1 && x[24:20] == b.rs2;
      end
      3'd4: begin
        d  = {x[31:12], 12'd0};
        ok = ok && d == b.imm && x[11:7] == b.rd;
      end
      default: begin
        d  = {{11{x[31]}}, x[31], x[19:12], x[20], x[30:21], 1'b0};
        ok = ok && d == b.imm && x[11:7] == b.rd;
      end
    endcase
    return ok;
  endfunction

  vec_t    vecs[16];
  bundle_t q[$];
  bundle_t nb;
  logic [31:0] m_addr;
  int          m_errs;
  int          cum_err;
  bit          xfer;
  bit          acc;

  initial begin
    vecs[0]  = mk(3'd1, 7'h13, 3'd0, 7'd0,    5'd1, 5'd0, 5'd0, 32'd5,          32'h0050_0093, 1'b0);
    vecs[1]  = mk(3'd2, 7'h23, 3'd2, 7'd0,    5'd0, 5'd2, 5'd1, -32'sd200,      32'hf211_2c23, 1'b0);
    vecs[2]  = mk(3'd5, 7'h6f, 3'd0, 7'd0,    5'd0, 5'd0, 5'd0, -32'sd200,      32'hf39f_f06f, 1'b0);
    vecs[3]  = mk(3'd4, 7'h37, 3'd0, 7'd0,    5'd2, 5'd0, 5'd0, 32'h000c_8000,  32'h000c_8137, 1'b0);
    vecs[4]  = mk(3'd4, 7'h37, 3'd0, 7'd0,    5'd2, 5'd0, 5'd0, 32'h000c_8001,  32'h0000_0013, 1'b1);
    vecs[5]  = mk(3'd1, 7'h13, 3'd0, 7'd0,    5'd1, 5'd0, 5'd0, 32'd2048,       32'h0000_0013, 1'b1);
    vecs[6]  = mk(3'd3, 7'h63, 3'd0, 7'd0,    5'd0, 5'd0, 5'd0, 32'd3,          32'h0000_0013, 1'b1);
    vecs[7]  = mk(3'd0, 7'h33, 3'd0, 7'h20,   5'd1, 5'd2, 5'd3, 32'd0,          32'h4031_00b3, 1'b0);
    vecs[8]  = mk(3'd1, 7'h13, 3'd0, 7'd0,    5'd1, 5'd0, 5'd0, -32'sd2048,     32'h8000_0093, 1'b0);
    vecs[9]  = mk(3'd3, 7'h63, 3'd0, 7'd0,    5'd0, 5'd0, 5'd0, -32'sd4096,     32'h8000_0063, 1'b0);
    vecs[10] = mk(3'd5, 7'h6f, 3'd0, 7'd0,    5'd0, 5'd0, 5'd0, 32'd1048574,    32'h7fff_f06f, 1'b0);
    vecs[11] = mk(3'd5, 7'h6f, 3'd0, 7'd0,    5'd0, 5'd0, 5'd0, 32'd1048576,    32'h0000_0013, 1'b1);
    vecs[12] = mk(3'd6, 7'h33, 3'd0, 7'd0,    5'd1, 5'd2, 5'd3, 32'd0,          32'h0000_0013, 1'b1);
    vecs[13] = mk(3'd1, 7'h13, 3'd0, 7'd0,    5'd1, 5'd0, 5'd0, 32'd2047,       32'h7ff0_0093, 1'b0);
    vecs[14] = mk(3'd3, 7'h63, 3'd0, 7'd0,    5'd0, 5'd0, 5'd0, 32'd4094,       32'h7e00_0fe3, 1'b0);
    vecs[15] = mk(3'd3, 7'h63, 3'd0, 7'd0,    5'd0, 5'd0, 5'd0, -32'sd4098,     32'h0000_0013, 1'b1);

    // Reset state, with in_valid held high to show inputs are ignored in reset.
    drive(3'd1, 7'h13, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'd5);
    do_reset();
    in_valid = 1'b0;
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_out_instr", out_instr, 32'd0);
    chk("rst_out_err",   {31'd0, out_err}, 32'd0);
    chk("rst_err_count", {24'd0, err_count}, 32'd0);
    chk("rst_out_addr",  out_addr, BASE);
    chk("rst_in_ready",  {31'd0, in_ready}, 32'd1);

    // Directed table, streamed back-to-back with the sink always ready.
    out_ready = 1'b1;
    cum_err   = 0;
    for (int i = 0; i < 16; i++) begin
      drive(vecs[i].fmt, vecs[i].opcode, vecs[i].funct3, vecs[i].funct7,
            vecs[i].rd, vecs[i].rs1, vecs[i].rs2, vecs[i].imm);
      if (vecs[i].exp_err) cum_err++;
      @(negedge clk);
      chk($sformatf("vec%0d_valid", i), {31'd0, out_valid}, 32'd1);
      chk($sformatf("vec%0d_instr", i), out_instr, vecs[i].exp_instr);
      chk($sformatf("vec%0d_err", i),   {31'd0, out_err}, {31'd0, vecs[i].exp_err});
      chk($sformatf("vec%0d_addr", i),  out_addr, BASE + 32'(4 * i));
      chk($sformatf("vec%0d_errcnt", i), {24'd0, err_count}, 32'(cum_err));
    end
    in_valid = 1'b0;
    @(negedge clk);
    chk("table_drain_valid", {31'd0, out_valid}, 32'd0);

    // Back-pressure: first word stalls three cycles while a second waits.
    do_reset();
    out_ready = 1'b0;
    drive(3'd1, 7'h13, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'd5);
    @(negedge clk);
    drive(3'd4, 7'h37, 3'd0, 7'd0, 5'd2, 5'd0, 5'd0, 32'h000c_8000);
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("stall%0d_instr", k), out_instr, 32'h0050_0093);
      chk($sformatf("stall%0d_addr", k),  out_addr, BASE);
      chk($sformatf("stall%0d_ready", k), {31'd0, in_ready}, 32'd0);
      @(negedge clk);
    end
    out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    chk("bp_second_instr", out_instr, 32'h000c_8137);
    chk("bp_second_addr",  out_addr, BASE + 32'd4);
    chk("bp_second_valid", {31'd0, out_valid}, 32'd1);
    @(negedge clk);
    chk("bp_drained", {31'd0, out_valid}, 32'd0);
    chk("bp_next_addr", out_addr, BASE + 32'd8);

    // Reset with a word pending discards it; addressing restarts at BASE.
    out_ready = 1'b0;
    drive(3'd4, 7'h37, 3'd0, 7'd0, 5'd2, 5'd0, 5'd0, 32'h000c_8001);
    @(negedge clk);
    in_valid = 1'b0;
    chk("pend_valid", {31'd0, out_valid}, 32'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("pend_discard_valid", {31'd0, out_valid}, 32'd0);
    chk("pend_discard_errcnt", {24'd0, err_count}, 32'd0);
    out_ready = 1'b1;
    drive(3'd1, 7'h13, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'd5);
    @(negedge clk);
    in_valid = 1'b0;
    chk("post_rst_addr",  out_addr, BASE);
    chk("post_rst_instr", out_instr, 32'h0050_0093);

    // Randomized run against a queue-based scoreboard.
    do_reset();
    q.delete();
    m_addr = BASE;
    m_errs = 0;
    for (int c = 0; c < 600; c++) begin
      @(negedge clk);
      chk("rand_valid", {31'd0, out_valid}, {31'd0, q.size() != 0});
      chk("rand_errcnt", {24'd0, err_count}, 32'(m_errs));
      if (q.size() != 0) begin
        chk("rand_addr", out_addr, m_addr);
        chk("rand_err", {31'd0, out_err}, {31'd0, q[0].err});
        total++;
        if (!word_ok(q[0], out_instr)) begin
          bad++;
          $display("FAIL rand_word: got %h for fmt %0d imm %h err %0d",
                   out_instr, q[0].fmt, q[0].imm, q[0].err);
        end
      end
      nb.fmt    = 3'($urandom_range(0, 7));
      nb.opcode = 7'($urandom);
      nb.funct3 = 3'($urandom);
      nb.funct7 = 7'($urandom);
      nb.rd     = 5'($urandom);
      nb.rs1    = 5'($urandom);
      nb.rs2    = 5'($urandom);
      case ($urandom_range(0, 3))
        0:       nb.imm = 32'($urandom_range(0, 8191)) - 32'd4096;
        1:       nb.imm = $urandom;
        2:       nb.imm = (32'($urandom_range(0, 2097151)) - 32'd1048576) & ~32'd1;
        default: nb.imm = $urandom & 32'hFFFF_F000;
      endcase
      nb.err = model_illegal(nb.fmt, nb.imm);
      drive(nb.fmt, nb.opcode, nb.funct3, nb.funct7, nb.rd, nb.rs1, nb.rs2, nb.imm);
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      #1;
      chk("rand_in_ready", {31'd0, in_ready}, {31'd0, (q.size() == 0) || out_ready});
      xfer = (q.size() != 0) && out_ready;
      acc  = in_valid && ((q.size() == 0) || out_ready);
      if (xfer) begin
        void'(q.pop_front());
        m_addr = m_addr + 32'd4;
      end
      if (acc) begin
        q.push_back(nb);
        if (nb.err && m_errs < 255) m_errs++;
      end
    end

    in_valid = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
